// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: N-master byte-wide memory bus arbiter with RAM / IO window decode.
// Read data returns RD_LATENCY cycles after the access cycle, registered once more into m_rdata.
// Optional feature macro: MEM_BUS_ARBITER_LOCK_EN (burst lock keeps the last granted master on the bus).
//
// state  | meaning
// IDLE   | bus free, arbitrate current requests every cycle
// ACCESS | one cycle on the RAM or IO port, m_gnt pulsed for the winner
// WAIT   | read in flight, counting down until ram_din/io_din is valid
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int RD_LATENCY     = 1,
  parameter int ARB_MODE       = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pause,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*8-1:0]          m_wdata,
  input  logic [NUM_MASTERS-1:0]            m_lock,
  output logic [NUM_MASTERS-1:0]            m_gnt,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic [7:0]                        m_rdata,
  output logic                              ram_en,
  output logic                              ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_a,
  output logic [7:0]                        ram_dout,
  input  logic [7:0]                        ram_din,
  output logic                              io_en,
  output logic                              io_wr,
  output logic [2:0]                        io_sel,
  output logic [7:0]                        io_dout,
  input  logic [7:0]                        io_din
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       last_idx;
  logic [IDX_W-1:0]       idx_q;
  logic                   wr_q;
  logic                   io_q;
  logic [2:0]             cnt;

  logic [NUM_MASTERS-1:0] elig;
  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic                   lock_win;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic                   win_wr;
  logic [7:0]             win_wdata;
  logic                   win_io;
  logic                   unused_bits;

  assign unused_bits = ^{m_lock, win_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+1]};

  // Arbitration: pick the winner among eligible requests and mux its access fields.
  always_comb begin
    elig     = m_req;
    if (pause) elig = m_req & NUM_MASTERS'(1);
    win_vld  = |elig;
    win_idx  = '0;
    lock_win = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--)
        if (elig[i]) win_idx = IDX_W'(i);
    end else begin
      // Scan from the pointer; the descending loop leaves the nearest hit last.
      for (int k = NUM_MASTERS - 1; k >= 0; k--)
        if (elig[(int'(rr_ptr) + k) % NUM_MASTERS])
          win_idx = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
    end
`ifdef MEM_BUS_ARBITER_LOCK_EN
    if (elig[last_idx] && m_lock[last_idx]) begin
      win_idx  = last_idx;
      lock_win = 1'b1;
    end
`endif
    win_addr  = m_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win_wr    = m_wr[win_idx];
    win_wdata = m_wdata[int'(win_idx)*8 +: 8];
    win_io    = (win_addr[RAM_ADDR_WIDTH -: 2] == 2'b11);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = wr_q ? IDLE : WAIT;
      WAIT:    if (cnt == 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered bus outputs, latched access context, pointers and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gnt    <= '0;
      m_rvalid <= '0;
      m_rdata  <= '0;
      ram_en   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_a    <= '0;
      ram_dout <= '0;
      io_en    <= 1'b0;
      io_wr    <= 1'b0;
      io_sel   <= '0;
      io_dout  <= '0;
      rr_ptr   <= '0;
      last_idx <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      io_q     <= 1'b0;
      cnt      <= '0;
    end else begin
      m_gnt    <= '0;
      m_rvalid <= '0;
      ram_en   <= 1'b0;
      ram_wr   <= 1'b0;
      ram_a    <= '0;
      ram_dout <= '0;
      io_en    <= 1'b0;
      io_wr    <= 1'b0;
      io_sel   <= '0;
      io_dout  <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            m_gnt[win_idx] <= 1'b1;
            idx_q    <= win_idx;
            wr_q     <= win_wr;
            io_q     <= win_io;
            last_idx <= win_idx;
            if (!lock_win)
              rr_ptr <= (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
            if (win_io) begin
              io_en   <= 1'b1;
              io_wr   <= win_wr;
              io_sel  <= win_addr[2:0];
              io_dout <= win_wdata;
            end else begin
              ram_en   <= 1'b1;
              ram_wr   <= win_wr;
              ram_a    <= win_addr[RAM_ADDR_WIDTH-1:0];
              ram_dout <= win_wdata;
            end
          end
        end
        ACCESS: begin
          if (!wr_q) cnt <= 3'(RD_LATENCY);
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            m_rdata         <= io_q ? io_din : ram_din;
            m_rvalid[idx_q] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a fixed-priority and a round-robin instance,
// each with a cycle-level transaction model of the bus and a random master population.
module tb_mem_bus_arbiter;

  localparam int NM  = 3;
  localparam int AW  = 32;
  localparam int RAW = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   phase = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int    MODE = k;
    localparam int    RDL  = (k == 0) ? 1 : 2;
    localparam string PFX  = (k == 0) ? "fp" : "rr";

    logic [NM-1:0]    req = '0, wr = '0, lock = '0;
    logic [NM*AW-1:0] addr = '0;
    logic [NM*8-1:0]  wdata = '0;
    logic             pause = 1'b0;
    logic [7:0]       ram_din = '0, io_din = '0;
    logic [NM-1:0]    m_gnt, m_rvalid;
    logic [7:0]       m_rdata, ram_dout, io_dout;
    logic             ram_en, ram_wr, io_en, io_wr;
    logic [RAW-1:0]   ram_a;
    logic [2:0]       io_sel;
    logic [63:0]      all_out;

    assign all_out = 64'({m_gnt, m_rvalid, m_rdata, ram_en, ram_wr, ram_a, ram_dout,
                          io_en, io_wr, io_sel, io_dout});

    mem_bus_arbiter #(
      .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW),
      .RD_LATENCY(RDL), .ARB_MODE(MODE)
    ) dut (
      .clk(clk), .rst_n(rst_n), .pause(pause),
      .m_req(req), .m_wr(wr), .m_addr(addr), .m_wdata(wdata), .m_lock(lock),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
      .io_en(io_en), .io_wr(io_wr), .io_sel(io_sel), .io_dout(io_dout), .io_din(io_din)
    );

    // Model state: cycle numbers of the bus becoming free and of the pending read events.
    int            cyc = 0, idle_at = 0, acc_cyc = -10, rv_at = -1, cap_at = -1;
    int            rv_idx = 0, rr = 0, last = 0, w = 0, j = 0;
    bit            rv_io = 0, locked = 0, is_io = 0;
    logic [7:0]    cap_val = '0, exp_rdata = '0;
    logic [NM-1:0] e_gnt = '0, e_rv = '0;
    logic          e_ram_en = 0, e_io_en = 0, e_wr = 0;
    logic [RAW-1:0] e_ram_a = '0;
    logic [2:0]    e_sel = '0;
    logic [7:0]    e_dout = '0;
    logic [AW-1:0] a = '0;
    bit            mdl_wait = 0;

    initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check_val({PFX, "_rst_outs"}, all_out, 64'd0);
        req = '0; wr = '0; lock = '0; pause = 1'b0;
        idle_at = 0; acc_cyc = -10; rv_at = -1; cap_at = -1;
        rr = 0; last = 0; exp_rdata = '0;
        e_gnt = '0; e_ram_en = 0; e_io_en = 0; mdl_wait = 0;
      end else begin
        // Compare this cycle's outputs against what the model predicted last cycle.
        if (cyc == rv_at) exp_rdata = cap_val;
        e_rv = '0;
        if (cyc == rv_at) e_rv[rv_idx] = 1'b1;
        check_val({PFX, "_gnt"}, 64'(m_gnt), 64'(e_gnt));
        check_val({PFX, "_rvalid"}, 64'(m_rvalid), 64'(e_rv));
        check_val({PFX, "_rdata"}, 64'(m_rdata), 64'(exp_rdata));
        check_val({PFX, "_ram_en"}, 64'(ram_en), 64'(e_ram_en));
        check_val({PFX, "_io_en"}, 64'(io_en), 64'(e_io_en));
        if (e_ram_en) begin
          check_val({PFX, "_ram_wr"}, 64'(ram_wr), 64'(e_wr));
          check_val({PFX, "_ram_a"}, 64'(ram_a), 64'(e_ram_a));
          check_val({PFX, "_ram_dout"}, 64'(ram_dout), 64'(e_dout));
        end
        if (e_io_en) begin
          check_val({PFX, "_io_wr"}, 64'(io_wr), 64'(e_wr));
          check_val({PFX, "_io_sel"}, 64'(io_sel), 64'(e_sel));
          check_val({PFX, "_io_dout"}, 64'(io_dout), 64'(e_dout));
        end

        // Masters: a granted request is retired; others may drop or raise a new one.
        for (int i = 0; i < NM; i++) begin
          if (e_gnt[i]) req[i] = 1'b0;
          else if (req[i] && phase != 1 && $urandom_range(15) == 0) req[i] = 1'b0;
          if (!req[i] && !e_gnt[i] && (phase == 1 || $urandom_range(3) == 0)) begin
            req[i]             = 1'b1;
            wr[i]              = 1'($urandom_range(1));
            addr[i*AW +: AW]   = $urandom;
            wdata[i*8 +: 8]    = 8'($urandom);
            lock[i]            = 1'($urandom_range(1));
          end
        end
        pause   = (phase == 1) ? 1'b0 :
                  (phase == 2) ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
        ram_din = 8'($urandom);
        io_din  = 8'($urandom);
        if (cyc == cap_at) cap_val = rv_io ? io_din : ram_din;

        // Predict the next cycle from the requests the DUT samples at the coming edge.
        e_gnt = '0; e_ram_en = 0; e_io_en = 0;
        if (cyc >= idle_at) begin
          w = -1; locked = 0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
          if (req[last] && lock[last] && (!pause || last == 0)) begin
            w = last; locked = 1;
          end
`endif
          for (int n = 0; n < NM; n++) begin
            j = (MODE == 0) ? n : (rr + n) % NM;
            if (w < 0 && req[j] && (!pause || j == 0)) w = j;
          end
          if (w >= 0) begin
            a        = addr[w*AW +: AW];
            is_io    = (a[RAW:RAW-1] == 2'b11);
            e_gnt[w] = 1'b1;
            e_ram_en = !is_io;
            e_io_en  = is_io;
            e_wr     = wr[w];
            e_ram_a  = a[RAW-1:0];
            e_sel    = a[2:0];
            e_dout   = wdata[w*8 +: 8];
            last     = w;
            if (!locked) rr = (w + 1) % NM;
            acc_cyc  = cyc + 1;
            if (wr[w]) idle_at = cyc + 2;
            else begin
              idle_at = cyc + 2 + RDL;
              rv_at   = idle_at;
              cap_at  = cyc + 1 + RDL;
              rv_idx  = w;
              rv_io   = is_io;
            end
          end
        end
        mdl_wait = (cyc + 1 > acc_cyc) && (cyc + 1 < idle_at);
      end
    end
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_fp_outs_init", g_inst[0].all_out, 64'd0);
    check_val("rst_rr_outs_init", g_inst[1].all_out, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    phase = 0; repeat (800) @(posedge clk);
    phase = 1; repeat (800) @(posedge clk);
    phase = 2; repeat (800) @(posedge clk);

    // Asynchronous reset landing while the round-robin instance has a read in WAIT.
    phase = 1;
    for (int r = 0; r < 4; r++) begin
      found = 0;
      for (int t = 0; t < 200 && !found; t++) begin
        @(posedge clk);
        #2;
        if (g_inst[1].mdl_wait) found = 1;
      end
      check_val("reach_wait", 64'(found), 64'd1);
      rst_n = 1'b0;
      #1;
      check_val("rst_async_fp", g_inst[0].all_out, 64'd0);
      check_val("rst_async_rr", g_inst[1].all_out, 64'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (40) @(posedge clk);
    end

    phase = 0; repeat (400) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
